// File: rtl/or1200_fwd_sel.sv
// Operand-mux select producer: tracks EX/WB destinations, registers forwarding selects at ID->EX.
// One cycle of latency on selects and stage registers; lu_stall is combinational, and the freeze inputs hold state.
module or1200_fwd_sel #(
    parameter int AW    = 5,
    parameter int SEL_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_freeze_i,
    input  logic             ex_freeze_i,
    input  logic             wb_freeze_i,
    input  logic [AW-1:0]    id_rfa_addr_i,
    input  logic [AW-1:0]    id_rfb_addr_i,
    input  logic             id_rfa_en_i,
    input  logic             id_rfb_en_i,
    input  logic             id_imm_b_i,
    input  logic             id_rf_we_i,
    input  logic [AW-1:0]    id_rf_addrw_i,
    input  logic             id_is_load_i,
    input  logic             ex_flush_i,
    output logic [SEL_W-1:0] sel_a_o,
    output logic [SEL_W-1:0] sel_b_o,
    output logic             ex_rf_we_o,
    output logic [AW-1:0]    ex_rf_addrw_o,
    output logic             ex_is_load_o,
    output logic             wb_rf_we_o,
    output logic [AW-1:0]    wb_rf_addrw_o,
    output logic             lu_stall_o
);

    localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_EX  = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(3);

    logic [SEL_W-1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic             ex_rf_we_q, ex_rf_we_d, ex_is_load_q, ex_is_load_d;
    logic [AW-1:0]    ex_rf_addrw_q, ex_rf_addrw_d;
    logic             wb_rf_we_q, wb_rf_we_d;
    logic [AW-1:0]    wb_rf_addrw_q, wb_rf_addrw_d;

    logic hit_a_ex, hit_a_wb, hit_b_ex, hit_b_wb, lu_stall;
    logic [SEL_W-1:0] fwd_a, fwd_b;

    // r0 reads as zero, so a write to it is never a forwarding source
    assign hit_a_ex = ex_rf_we_q && (id_rfa_addr_i == ex_rf_addrw_q) && (|id_rfa_addr_i);
    assign hit_a_wb = wb_rf_we_q && (id_rfa_addr_i == wb_rf_addrw_q) && (|id_rfa_addr_i);
    assign hit_b_ex = ex_rf_we_q && (id_rfb_addr_i == ex_rf_addrw_q) && (|id_rfb_addr_i);
    assign hit_b_wb = wb_rf_we_q && (id_rfb_addr_i == wb_rf_addrw_q) && (|id_rfb_addr_i);

    assign lu_stall = ex_is_load_q && ex_rf_we_q && (|ex_rf_addrw_q) &&
                      ((id_rfa_en_i && hit_a_ex) || (id_rfb_en_i && !id_imm_b_i && hit_b_ex));

    always_comb begin
        fwd_a = SEL_RF;
        if (id_rfa_en_i && hit_a_ex)      fwd_a = SEL_EX;
        else if (id_rfa_en_i && hit_a_wb) fwd_a = SEL_WB;

        fwd_b = SEL_RF;
        if (id_imm_b_i)                   fwd_b = SEL_IMM;
        else if (id_rfb_en_i && hit_b_ex) fwd_b = SEL_EX;
        else if (id_rfb_en_i && hit_b_wb) fwd_b = SEL_WB;
    end

    always_comb begin
        sel_a_d       = sel_a_q;
        sel_b_d       = sel_b_q;
        ex_rf_we_d    = ex_rf_we_q;
        ex_rf_addrw_d = ex_rf_addrw_q;
        ex_is_load_d  = ex_is_load_q;
        if (!ex_freeze_i) begin
            if (id_freeze_i || lu_stall || ex_flush_i) begin
                sel_a_d       = SEL_RF;
                sel_b_d       = SEL_RF;
                ex_rf_we_d    = 1'b0;
                ex_rf_addrw_d = '0;
                ex_is_load_d  = 1'b0;
            end else begin
                sel_a_d       = fwd_a;
                sel_b_d       = fwd_b;
                ex_rf_we_d    = id_rf_we_i;
                ex_rf_addrw_d = id_rf_addrw_i;
                ex_is_load_d  = id_is_load_i;
            end
        end

        wb_rf_we_d    = wb_rf_we_q;
        wb_rf_addrw_d = wb_rf_addrw_q;
        if (!wb_freeze_i) begin
            // a frozen EX stage leaves nothing to retire, so WB takes a bubble
            wb_rf_we_d    = ex_freeze_i ? 1'b0 : ex_rf_we_q;
            wb_rf_addrw_d = ex_freeze_i ? '0   : ex_rf_addrw_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_a_q       <= SEL_RF;
            sel_b_q       <= SEL_RF;
            ex_rf_we_q    <= 1'b0;
            ex_rf_addrw_q <= '0;
            ex_is_load_q  <= 1'b0;
            wb_rf_we_q    <= 1'b0;
            wb_rf_addrw_q <= '0;
        end else begin
            sel_a_q       <= sel_a_d;
            sel_b_q       <= sel_b_d;
            ex_rf_we_q    <= ex_rf_we_d;
            ex_rf_addrw_q <= ex_rf_addrw_d;
            ex_is_load_q  <= ex_is_load_d;
            wb_rf_we_q    <= wb_rf_we_d;
            wb_rf_addrw_q <= wb_rf_addrw_d;
        end
    end

    assign sel_a_o       = sel_a_q;
    assign sel_b_o       = sel_b_q;
    assign ex_rf_we_o    = ex_rf_we_q;
    assign ex_rf_addrw_o = ex_rf_addrw_q;
    assign ex_is_load_o  = ex_is_load_q;
    assign wb_rf_we_o    = wb_rf_we_q;
    assign wb_rf_addrw_o = wb_rf_addrw_q;
    assign lu_stall_o    = lu_stall;

endmodule

// File: tb/tb_or1200_fwd_sel.sv
// Bench for or1200_fwd_sel: directed hazard scenarios then randomized traffic against a pipeline-slot model.
module tb_or1200_fwd_sel;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       id_freeze, ex_freeze, wb_freeze, ex_flush;
    logic [4:0] id_rfa_addr, id_rfb_addr, id_rf_addrw;
    logic       id_rfa_en, id_rfb_en, id_imm_b, id_rf_we, id_is_load;
    logic [1:0] sel_a, sel_b;
    logic       ex_rf_we, ex_is_load, wb_rf_we, lu_stall;
    logic [4:0] ex_rf_addrw, wb_rf_addrw;

    or1200_fwd_sel dut (
        .clk_i(clk), .rst_ni(rst_n),
        .id_freeze_i(id_freeze), .ex_freeze_i(ex_freeze), .wb_freeze_i(wb_freeze),
        .id_rfa_addr_i(id_rfa_addr), .id_rfb_addr_i(id_rfb_addr),
        .id_rfa_en_i(id_rfa_en), .id_rfb_en_i(id_rfb_en), .id_imm_b_i(id_imm_b),
        .id_rf_we_i(id_rf_we), .id_rf_addrw_i(id_rf_addrw), .id_is_load_i(id_is_load),
        .ex_flush_i(ex_flush),
        .sel_a_o(sel_a), .sel_b_o(sel_b),
        .ex_rf_we_o(ex_rf_we), .ex_rf_addrw_o(ex_rf_addrw), .ex_is_load_o(ex_is_load),
        .wb_rf_we_o(wb_rf_we), .wb_rf_addrw_o(wb_rf_addrw), .lu_stall_o(lu_stall)
    );

    typedef struct packed {
        logic       we;
        logic [4:0] a;
        logic       ld;
    } slot_t;

    int    n_checks = 0;
    int    n_err    = 0;
    slot_t ex_m, wb_m;
    logic [1:0] sa_m, sb_m;
    logic  stall_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Youngest producer holding the register wins; r0 never has a producer.
    function automatic logic [1:0] src_sel(input logic [4:0] a, input logic en);
        slot_t      prod [2];
        logic [1:0] code [2];
        prod[0] = ex_m; code[0] = 2'd2;
        prod[1] = wb_m; code[1] = 2'd3;
        if (!en || a == 5'd0) return 2'd0;
        for (int i = 0; i < 2; i++)
            if (prod[i].we && prod[i].a == a) return code[i];
        return 2'd0;
    endfunction

    function automatic logic model_stall();
        if (!(ex_m.ld && ex_m.we && ex_m.a != 5'd0)) return 1'b0;
        return (id_rfa_en && id_rfa_addr == ex_m.a) ||
               (id_rfb_en && !id_imm_b && id_rfb_addr == ex_m.a);
    endfunction

    task automatic model_reset();
        ex_m = '0; wb_m = '0; sa_m = 2'd0; sb_m = 2'd0;
    endtask

    task automatic check_regs();
        chk("sel_a", sel_a, sa_m);
        chk("sel_b", sel_b, sb_m);
        chk("ex_rf_we", ex_rf_we, ex_m.we);
        chk("ex_rf_addrw", ex_rf_addrw, ex_m.a);
        chk("ex_is_load", ex_is_load, ex_m.ld);
        chk("wb_rf_we", wb_rf_we, wb_m.we);
        chk("wb_rf_addrw", wb_rf_addrw, wb_m.a);
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic cycle();
        logic       st;
        logic [1:0] na, nb;
        slot_t      id_s;
        #1;
        st = model_stall();
        stall_seen = lu_stall;
        chk("lu_stall", lu_stall, st);
        na = src_sel(id_rfa_addr, id_rfa_en);
        nb = id_imm_b ? 2'd1 : src_sel(id_rfb_addr, id_rfb_en);
        id_s = '{we: id_rf_we, a: id_rf_addrw, ld: id_is_load};
        @(posedge clk);
        if (!wb_freeze) wb_m = ex_freeze ? slot_t'(0) : ex_m;
        if (!ex_freeze) begin
            if (id_freeze || st || ex_flush) begin
                ex_m = '0; sa_m = 2'd0; sb_m = 2'd0;
            end else begin
                ex_m = id_s; sa_m = na; sb_m = nb;
            end
        end
        @(negedge clk);
        check_regs();
    endtask

    task automatic issue(input logic we, input logic [4:0] wa, input logic ld,
                         input logic ena, input logic [4:0] ra,
                         input logic enb, input logic [4:0] rb, input logic imm);
        id_rf_we = we; id_rf_addrw = wa; id_is_load = ld;
        id_rfa_en = ena; id_rfa_addr = ra;
        id_rfb_en = enb; id_rfb_addr = rb; id_imm_b = imm;
        id_freeze = 1'b0; ex_freeze = 1'b0; wb_freeze = 1'b0; ex_flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        chk("reset_outputs", {sel_a, sel_b, ex_rf_we, ex_rf_addrw, ex_is_load,
                              wb_rf_we, wb_rf_addrw, lu_stall}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // EX forwarding: add r3; add r4 <- r3, r5
        issue(1, 3, 0, 1, 1, 1, 2, 0); cycle();
        issue(1, 3, 0, 0, 0, 0, 0, 0); cycle();
        issue(1, 4, 0, 1, 3, 1, 5, 0); cycle();
        chk("ex_fwd_sel_a", sel_a, 2'd2);
        chk("ex_fwd_sel_b", sel_b, 2'd0);

        // WB forwarding on B through one unrelated instruction
        issue(1, 3, 0, 0, 0, 0, 0, 0); cycle();
        issue(1, 9, 0, 1, 1, 1, 2, 0); cycle();
        issue(1, 4, 0, 1, 5, 1, 3, 0); cycle();
        chk("wb_fwd_sel_b", sel_b, 2'd3);

        // Load-use: one stall cycle with bubble, then WB forward
        issue(1, 7, 1, 0, 0, 0, 0, 0); cycle();
        issue(1, 8, 0, 1, 7, 0, 0, 0); cycle();
        chk("lu_stall_seen", stall_seen, 1'b1);
        chk("lu_bubble_we", ex_rf_we, 1'b0);
        cycle();
        chk("lu_stall_gone", stall_seen, 1'b0);
        chk("lu_sel_a_wb", sel_a, 2'd3);

        // r0 is never forwarded; immediate always selects simm
        issue(1, 0, 1, 0, 0, 0, 0, 0); cycle();
        issue(1, 6, 0, 1, 0, 1, 0, 1); cycle();
        chk("r0_no_stall", stall_seen, 1'b0);
        chk("r0_sel_a", sel_a, 2'd0);
        chk("imm_sel_b", sel_b, 2'd1);
        issue(1, 6, 0, 1, 0, 1, 6, 1); cycle();
        chk("imm_over_hit", sel_b, 2'd1);

        // EX freeze holds sel and destination, then a flush injects a bubble
        issue(1, 3, 0, 0, 0, 0, 0, 0); cycle();
        issue(1, 4, 0, 1, 3, 0, 0, 0); cycle();
        for (int i = 0; i < 4; i++) begin
            id_freeze = 1'b1; ex_freeze = 1'b1;
            cycle();
            chk("frz_sel_a", sel_a, 2'd2);
            chk("frz_ex_addrw", ex_rf_addrw, 5'd4);
        end
        issue(1, 5, 0, 1, 4, 0, 0, 0); ex_flush = 1'b1; cycle();
        chk("flush_we", ex_rf_we, 1'b0);
        chk("flush_sel_a", sel_a, 2'd0);

        // Asynchronous reset in the middle of a load-use hazard
        issue(1, 7, 1, 0, 0, 0, 0, 0); cycle();
        issue(1, 8, 0, 1, 7, 0, 0, 0);
        #1;
        chk("pre_rst_stall", lu_stall, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {sel_a, sel_b, ex_rf_we, ex_rf_addrw, ex_is_load,
                                  wb_rf_we, wb_rf_addrw, lu_stall}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_sel_a", sel_a, 2'd0);

        // Randomized traffic with legal freeze nesting
        for (int n = 0; n < 3000; n++) begin
            wb_freeze   = ($urandom_range(0, 9) == 0);
            ex_freeze   = wb_freeze | ($urandom_range(0, 9) == 0);
            id_freeze   = ex_freeze | ($urandom_range(0, 9) == 0);
            ex_flush    = ($urandom_range(0, 11) == 0);
            id_rfa_addr = 5'($urandom_range(0, 3));
            id_rfb_addr = 5'($urandom_range(0, 3));
            id_rf_addrw = 5'($urandom_range(0, 3));
            id_rfa_en   = 1'($urandom);
            id_rfb_en   = 1'($urandom);
            id_imm_b    = ($urandom_range(0, 3) == 0);
            id_rf_we    = ($urandom_range(0, 3) != 0);
            id_is_load  = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
